// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receiver:
// FSM state encoding, frame length and parity/cycle-count helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        RELEASE
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // 64-bit product keeps large frequency * microsecond values from overflowing.
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned hz);
        longint unsigned prod;
        prod = longint'(us) * longint'(hz);
        return int'(prod / 64'd1_000_000);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status handshake between a byte producer and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       error;
    logic       busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, error, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, error, busy
    );
endinterface

// File: rtl/ps2_clk_filter.sv
// 8-sample glitch filter on the raw PS/2 clock pin with a one-cycle
// falling-edge pulse on the filtered level.
module ps2_clk_filter (
    input  logic clk,
    input  logic nRESET,
    input  logic clk_in,
    output logic level,
    output logic fall_edge
);
    logic [7:0] sreg;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sreg      <= '1;
            level     <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            sreg      <= {sreg[6:0], clk_in};
            fall_edge <= 1'b0;
            if (sreg == '0) begin
                level <= 1'b0;
                if (level) fall_edge <= 1'b1;
            end else if (sreg == '1) begin
                level <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, ack).
// Define PS2_TX_ACK_CHECK_EN to report a missing device acknowledge as an error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 15000
) (
    input  logic          clk,
    input  logic          nRESET,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);
    localparam int unsigned INH_RAW = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
    localparam int unsigned TMO_RAW = us_to_cycles(TIMEOUT_US, CLK_FREQ_HZ);
    localparam int unsigned INH_N   = (INH_RAW < 1) ? 1 : INH_RAW;
    localparam int unsigned TMO_N   = (TMO_RAW < 1) ? 1 : TMO_RAW;
    localparam int unsigned INH_W   = cnt_width(INH_N);
    localparam int unsigned TMO_W   = cnt_width(TMO_N);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 3);

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    ps2_state_e       state, state_nx;
    logic [7:0]       data_r;
    logic             par_r;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_flag;
    logic             dat_r;
    logic             clk_level;
    logic             fall_edge;
    logic             inh_last;
    logic             tmo_hit;
    logic             ack_nack;
    logic             done_c;
    logic             error_c;
    logic [8:0]       frame;

    ps2_clk_filter u_clk_filter (
        .clk       (clk),
        .nRESET    (nRESET),
        .clk_in    (ps2_clk_in),
        .level     (clk_level),
        .fall_edge (fall_edge)
    );

    assign frame    = {par_r, data_r};
    assign inh_last = (inh_cnt == INH_W'(INH_N - 1));
    assign tmo_hit  = (tmo_cnt == TMO_W'(TMO_N - 1));
    assign ack_nack = ACK_CHECK && dat_r;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        done_c     = 1'b0;
        error_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tx_valid) state_nx = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_last) begin
                    ps2_dat_oe = 1'b1;
                    state_nx   = REQ;
                end
            end
            REQ: begin
                if (tmo_hit) begin
                    error_c  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    ps2_dat_oe = 1'b1;
                    if (fall_edge) state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (tmo_hit) begin
                    error_c  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    ps2_dat_oe = ~frame[bit_cnt];
                    if (fall_edge && bit_cnt == LAST_BIT) state_nx = ACK;
                end
            end
            ACK: begin
                if (tmo_hit) begin
                    error_c  = 1'b1;
                    state_nx = IDLE;
                end else if (fall_edge) begin
                    error_c  = ack_nack;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (clk_level && dat_r) begin
                    done_c   = ~err_flag;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            data_r   <= '0;
            par_r    <= 1'b0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
            dat_r    <= 1'b1;
        end else begin
            dat_r <= ps2_dat_in;
            case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        data_r   <= bus.tx_data;
                        par_r    <= odd_parity(bus.tx_data);
                        bit_cnt  <= '0;
                        inh_cnt  <= '0;
                        tmo_cnt  <= '0;
                        err_flag <= 1'b0;
                    end
                end
                INHIBIT: if (!inh_last) inh_cnt <= inh_cnt + 1'b1;
                SHIFT:   if (fall_edge && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
                ACK:     if (fall_edge && ack_nack) err_flag <= 1'b1;
                default: ;
            endcase
            // Timeout budget spans inhibit through acknowledge; saturates at the limit.
            if ((state inside {INHIBIT, REQ, SHIFT, ACK}) && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_c;
    assign bus.error    = error_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model (40-cycle clock period).
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic nRESET;
    logic ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic clk_line, dat_line;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ (1000000),
        .INHIBIT_US  (100),
        .TIMEOUT_US  (15000)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .bus        (bus),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         is_done;
        bit         chk_frame;
        logic [7:0] b;
        logic       p;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] m_byte = '0;
    logic       m_par  = 1'b0;
    logic       m_stop = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done/error pulse is matched against the next expected outcome.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (nRESET && (bus.done || bus.error)) begin
            check("done_error_exclusive", int'(bus.done && bus.error), 0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: done=%0d error=%0d, no outcome expected", bus.done, bus.error);
            end else begin
                e = exp_q.pop_front();
                check("outcome_done", int'(bus.done), int'(e.is_done));
                check("outcome_error", int'(bus.error), int'(!e.is_done));
                if (e.chk_frame) begin
                    check("frame_byte", int'(m_byte), int'(e.b));
                    check("frame_parity", int'(m_par), int'(e.p));
                    check("frame_stop", int'(m_stop), 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_before_send", int'(bus.tx_ready), 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        check("busy_after_accept", int'(bus.busy), 1);
    endtask

    // mode: 0 normal, 1 no acknowledge, 2 clock glitch in SHIFT, 3 stop after 4th data bit
    task automatic dev_xfer(input int mode);
        int n;
        logic [9:0] bits;
        n = 0;
        bits = '0;
        @(negedge clk);
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_cycles", n, 100);
        check("start_bit", int'(dat_line), 0);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(posedge clk);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = dat_line;
            if (mode == 3 && i == 3) return;
            if (i == 9) begin
                m_byte      = bits[7:0];
                m_par       = bits[8];
                m_stop      = bits[9];
                dev_dat_low = (mode != 1);
            end
            if (mode == 2 && i == 4) begin
                repeat (6) @(posedge clk);
                dev_clk_low = 1'b1;
                repeat (5) @(posedge clk);
                dev_clk_low = 1'b0;
                repeat (9) @(posedge clk);
            end else begin
                repeat (20) @(posedge clk);
            end
            if (i == 10) dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("returns_idle", int'(bus.busy), 0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       p;
        int         mode;
    } vec_t;

    vec_t vecs[5];
    bit   nack_done;

    initial begin
        int n;
        // odd parity: ED has six ones, 01 one, FF eight, A5 four, 3C four
        vecs[0] = '{8'hED, 1'b1, 0};
        vecs[1] = '{8'h01, 1'b0, 0};
        vecs[2] = '{8'hFF, 1'b1, 0};
        vecs[3] = '{8'hA5, 1'b1, 2};
        vecs[4] = '{8'h3C, 1'b1, 1};
`ifdef PS2_TX_ACK_CHECK_EN
        nack_done = 1'b0;
`else
        nack_done = 1'b1;
`endif
        nRESET       = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", int'(bus.tx_ready), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_clk_oe", int'(ps2_clk_oe), 0);
        check("reset_dat_oe", int'(ps2_dat_oe), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_error", int'(bus.error), 0);
        nRESET = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[k]) begin
            exp_q.push_back('{(vecs[k].mode != 1) || nack_done, 1'b1, vecs[k].b, vecs[k].p});
            send(vecs[k].b);
            dev_xfer(vecs[k].mode);
            wait_idle();
            repeat (30) @(negedge clk);
        end

        // device never clocks: timeout error in the 15000th cycle after accept
        exp_q.push_back('{1'b0, 1'b0, 8'h00, 1'b0});
        send(8'h5A);
        n = 0;
        while (n < 16000) begin
            @(negedge clk);
            n++;
            if (bus.error) break;
        end
        check("timeout_cycle", n, 15000);
        @(negedge clk);
        check("timeout_clk_oe", int'(ps2_clk_oe), 0);
        check("timeout_dat_oe", int'(ps2_dat_oe), 0);
        check("timeout_tx_ready", int'(bus.tx_ready), 1);
        repeat (30) @(negedge clk);

        // reset after the 4th data bit of 0x00 (bit 3 = 0, so data is being pulled low)
        send(8'h00);
        dev_xfer(3);
        @(negedge clk);
        check("abort_dat_oe_before", int'(ps2_dat_oe), 1);
        #2 nRESET = 1'b0;
        #1;
        check("abort_clk_oe", int'(ps2_clk_oe), 0);
        check("abort_dat_oe", int'(ps2_dat_oe), 0);
        check("abort_tx_ready", int'(bus.tx_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        repeat (50) @(negedge clk);

        // odd parity of F4 (five ones) is 0
        exp_q.push_back('{1'b1, 1'b1, 8'hF4, 1'b0});
        send(8'hF4);
        dev_xfer(0);
        wait_idle();
        repeat (30) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
